ram_burst_master: RTL and testbench
===================================

# ram_burst_master

Initiator for the team's single-port synchronous RAM (registered read data, one-cycle read latency, write on clock edge when `we` is high). It accepts burst commands over a valid/ready handshake and moves data between the RAM and two valid/ready streams. Write bursts go from the write stream into RAM; read bursts go from RAM onto the read stream, with full backpressure support. It sits between DMA/streaming logic and any instance of the RAM.

## Interface

Parameters:
- `A`, 10: RAM address bits.
- `D`, 8: RAM data bits.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_rw` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in A: start address.
- `cmd_len` in A: burst length minus 1 (1..2^A words).
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in D: write stream.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out D: read stream.
- `ram_addr` out A / `ram_din` out D / `ram_we` out 1 / `ram_dout` in D: RAM port.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse on the cycle the block returns to IDLE.

## Operation

States:
- IDLE: `cmd_ready`=1. A handshake captures addr/len into the address counter and the issue/deliver counters, then moves to WRITE or READ on the next cycle.
- WRITE:
  - `wr_ready`=1.
  - `ram_we` = `wr_valid`, `ram_din` = `wr_data`, `ram_addr` = current address counter (combinational from registered state).
  - Each handshake increments the address modulo 2^A.
  - The last handshake (len+1 words) moves the block to IDLE and pulses `done` on the next cycle.
- READ:
  - The block issues a RAM read (drive `ram_addr`, `ram_we`=0) when words remain to issue and (fifo occupancy + reads in flight − pop this cycle) < 2.
  - Data returns on `ram_dout` the following cycle and is pushed into a 2-entry output FIFO.
  - `rd_valid` = FIFO not empty; `rd_data` = FIFO head. A pop occurs when `rd_valid` and `rd_ready` are both high.
  - When all len+1 words have been delivered, the block moves to IDLE and pulses `done`.
- `ram_we` is never high outside WRITE. `cmd_ready` is 0 in WRITE and READ.
- Address wrap: a burst crossing 2^A−1 continues at 0.
- Read-word order equals address order; no word is dropped or duplicated under any `rd_ready` pattern.

Reset (async, any state):
- State goes to IDLE.
- Counters and the FIFO are cleared; in-flight read data is discarded.
- Outputs: `cmd_ready`=1 after release (0 while `reset` is high is also acceptable), `wr_ready`=0, `rd_valid`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `done`=0.
- Reset mid-burst performs no further RAM writes.

## Timing

- Command accept at cycle t: WRITE/READ is active from t+1.
- Write: one word per cycle while `wr_valid` is high. The RAM write happens at the same edge as the handshake.
- Read:
  - First issue at t+1.
  - First `rd_valid` at t+2, i.e. two cycles after command accept.
  - Sustained one word per cycle while `rd_ready` is held high.
- `rd_ready` low: at most 2 words are buffered and issuing stalls. Throughput recovers the cycle after `rd_ready` returns high.
- `done` is high for one cycle, coincident with `cmd_ready` rising. A new command may be accepted in that same cycle.
- `wr_valid` gaps insert idle cycles with `ram_we`=0; the address does not advance.

## Test plan

- Write burst `cmd_addr`=0x010, len=3 (4 words), data 0xA0..0xA3 back-to-back: exactly 4 `ram_we` cycles at addresses 0x010..0x013; `done` is 1 cycle after the last word.
- Read back the same range with `rd_ready`=1: `rd_data` = 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, the first at accept+2; `done` follows the last pop.
- Same read with `rd_ready` toggling 1,0,0,1,…: identical data sequence, never more than 2 words buffered, no `ram_addr` issue while the FIFO plus in-flight count is full.
- Wrap: write at addr 0x3FE, len=3 → writes to 0x3FE, 0x3FF, 0x000, 0x001. Reading back at 0x3FE returns the same 4 values.
- Single-word bursts (len=0), write then read, with `wr_valid` delayed 5 cycles: `ram_we` pulses once, `rd_data` is correct, `busy` drops with `done`.
- Assert `reset` mid-read (after 2 of 8 words) and mid-write: `rd_valid`, `ram_we`, `busy` go to 0 immediately; after release `cmd_ready`=1 and a new burst completes correctly.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM: write bursts drain a valid/ready
// stream into RAM, read bursts stream RAM words out through a 2-entry fall-through FIFO.
module ram_burst_master #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_rw,
    input  logic [A-1:0] cmd_addr,
    input  logic [A-1:0] cmd_len,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [D-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [D-1:0] rd_data,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t       state, state_nx;
    logic [A-1:0] addr_q;
    logic [A:0]   issue_left, deliver_left;   // one extra bit: a burst can be 2^A words
    logic         inflight_q;
    logic [D-1:0] fifo_mem [2];
    logic         fifo_wp, fifo_rp;
    logic [1:0]   fifo_cnt;
    logic         done_q;

    logic         cmd_fire, wr_fire, issue, pop, push, fifo_pop;
    logic [1:0]   avail;

    assign cmd_fire = (state == IDLE) && cmd_valid;
    assign wr_fire  = (state == WRITE) && wr_valid;

    // The word returning from RAM this cycle is visible at once when the FIFO is empty,
    // which gives the two-cycle accept-to-data latency.
    assign rd_valid = (state == READ) && ((fifo_cnt != 2'd0) || inflight_q);
    assign rd_data  = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : ram_dout;
    assign pop      = rd_valid && rd_ready;
    assign fifo_pop = pop && (fifo_cnt != 2'd0);
    assign push     = inflight_q && !(pop && (fifo_cnt == 2'd0));

    // Words buffered or in flight that will still be held after this cycle's pop.
    assign avail    = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};

    assign ram_addr = addr_q;
    assign busy     = (state != IDLE);
    assign done     = done_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_din   = '0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nx = cmd_rw ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                ram_din  = wr_data;
                if (wr_valid && (issue_left == (A+1)'(1)))
                    state_nx = IDLE;
            end
            READ: begin
                issue = (issue_left != '0) && (avail < 2'd2);
                if (pop && (deliver_left == (A+1)'(1)))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            inflight_q   <= 1'b0;
            fifo_wp      <= 1'b0;
            fifo_rp      <= 1'b0;
            fifo_cnt     <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            state      <= state_nx;
            done_q     <= (state != IDLE) && (state_nx == IDLE);
            inflight_q <= issue;
            if (cmd_fire) begin
                addr_q       <= cmd_addr;
                issue_left   <= {1'b0, cmd_len} + (A+1)'(1);
                deliver_left <= {1'b0, cmd_len} + (A+1)'(1);
            end else if (wr_fire || issue) begin
                addr_q     <= addr_q + A'(1);
                issue_left <= issue_left - (A+1)'(1);
            end
            if (pop)
                deliver_left <= deliver_left - (A+1)'(1);
            if (push)
                fifo_wp <= ~fifo_wp;
            if (fifo_pop)
                fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    // NOTE: FIFO storage is not reset; clearing the pointers and count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wp] <= ram_dout;
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, a shadow memory as the
// reference model, directed bursts plus randomized bursts, gaps and rd_ready patterns.
module tb_ram_burst_master;

    localparam int A = 10;
    localparam int D = 8;
    localparam int N = 1 << A;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready, cmd_rw;
    logic [A-1:0] cmd_addr, cmd_len;
    logic         wr_valid, wr_ready;
    logic [D-1:0] wr_data;
    logic         rd_valid, rd_ready;
    logic [D-1:0] rd_data;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic         ram_we;
    logic [D-1:0] ram_dout;
    logic         busy, done;

    ram_burst_master #(.A(A), .D(D)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    logic [D-1:0] ram [N];
    int we_count = 0;
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_din;
            we_count++;
        end
        ram_dout <= ram[ram_addr];
    end

    logic [D-1:0] ref_mem [N];
    logic [D-1:0] wdata [N];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    task automatic send_cmd(input logic rw, input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = A'(addr);
        cmd_len   = A'(len);
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
    endtask

    // Write len+1 words from wdata[]; abort_after >= 0 asserts reset while that word is offered.
    task automatic do_write(input int addr, input int len, input int first_gap,
                            input int max_gap, input int abort_after);
        int start;
        int gap;
        send_cmd(1'b1, addr, len);
        start = we_count;
        for (int i = 0; i <= len; i++) begin
            gap = (i == 0) ? first_gap : int'($urandom_range(0, max_gap));
            repeat (gap) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                wr_valid  = 1'b0;
                #1;
                check("wr_gap_we", ram_we, 0);
                check("wr_gap_busy", busy, 1);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_valid  = 1'b1;
            wr_data   = wdata[i];
            #1;
            if (i == abort_after) begin
                reset = 1'b1;
                #1;
                check("wr_abort_we", ram_we, 0);
                check("wr_abort_busy", busy, 0);
                check("wr_abort_wr_ready", wr_ready, 0);
                @(negedge clk);
                reset    = 1'b0;
                wr_valid = 1'b0;
                #1;
                check("wr_abort_count", we_count - start, i);
                check("wr_abort_cmd_ready", cmd_ready, 1);
                return;
            end
            check("wr_we", ram_we, 1);
            check("wr_ready", wr_ready, 1);
            check("wr_addr", ram_addr, (addr + i) % N);
            check("wr_din", ram_din, wdata[i]);
            ref_mem[(addr + i) % N] = wdata[i];
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("wr_done", done, 1);
        check("wr_done_busy", busy, 0);
        check("wr_done_cmd_ready", cmd_ready, 1);
        check("wr_we_count", we_count - start, len + 1);
        @(negedge clk);
        #1;
        check("wr_done_pulse", done, 0);
    endtask

    // mode 0: rd_ready held high; 1: pattern 1,0,0,1; 2: random.
    task automatic do_read(input int addr, input int len, input int mode, input int abort_after);
        logic [D-1:0] exp_q[$];
        int delivered;
        int cyc;
        int issued;
        logic rdy;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i <= len; i++)
            exp_q.push_back(ref_mem[(addr + i) % N]);
        send_cmd(1'b0, addr, len);
        delivered = 0;
        cyc = 0;
        while (delivered <= len && cyc < 200 + 4 * len) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[3 - (cyc % 4)];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            #1;
            cyc++;
            issued = (int'(ram_addr) - addr + N) % N;
            check("rd_outstanding_le2", 32'(issued - delivered <= 2), 1);
            check("rd_ram_we", ram_we, 0);
            check("rd_busy", busy, 1);
            if (cyc == 1)
                check("rd_valid_t1", rd_valid, 0);
            if (mode == 0 && cyc >= 2)
                check("rd_valid_stream", rd_valid, 1);
            if (rd_valid && rd_ready) begin
                check("rd_data", rd_data, exp_q[delivered]);
                delivered++;
                if (delivered == abort_after) begin
                    reset = 1'b1;
                    #1;
                    check("rd_abort_valid", rd_valid, 0);
                    check("rd_abort_busy", busy, 0);
                    check("rd_abort_we", ram_we, 0);
                    @(negedge clk);
                    reset    = 1'b0;
                    rd_ready = 1'b0;
                    #1;
                    check("rd_abort_cmd_ready", cmd_ready, 1);
                    return;
                end
            end
        end
        if (delivered <= len)
            check("rd_timeout_words", delivered, len + 1);
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        check("rd_done", done, 1);
        check("rd_done_busy", busy, 0);
        check("rd_done_valid", rd_valid, 0);
        @(negedge clk);
        #1;
        check("rd_done_pulse", done, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int addr, len;
        for (int i = 0; i < N; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        reset_dut();

        // Directed write/read at 0x010, then with throttled rd_ready.
        for (int i = 0; i < 4; i++) wdata[i] = D'(8'hA0 + i);
        do_write(12'h010, 3, 0, 0, -1);
        do_read(12'h010, 3, 0, -1);
        do_read(12'h010, 3, 1, -1);

        // Address wrap across the top of the RAM.
        for (int i = 0; i < 4; i++) wdata[i] = D'($urandom);
        do_write(12'h3FE, 3, 0, 0, -1);
        do_read(12'h3FE, 3, 0, -1);
        do_read(12'h3FE, 3, 2, -1);

        // Single-word bursts with a delayed write word.
        wdata[0] = D'($urandom);
        do_write(12'h155, 0, 5, 0, -1);
        do_read(12'h155, 0, 0, -1);

        // Reset in the middle of a read, then of a write.
        for (int i = 0; i < 8; i++) wdata[i] = D'($urandom);
        do_write(12'h200, 7, 0, 0, -1);
        do_read(12'h200, 7, 0, 2);
        do_read(12'h200, 7, 2, -1);
        for (int i = 0; i < 8; i++) wdata[i] = D'($urandom);
        do_write(12'h300, 7, 0, 1, 3);
        do_read(12'h300, 7, 1, -1);
        for (int i = 0; i < 8; i++) wdata[i] = D'($urandom);
        do_write(12'h300, 7, 0, 2, -1);
        do_read(12'h300, 7, 0, -1);

        // Randomized bursts.
        for (int n = 0; n < 12; n++) begin
            addr = int'($urandom_range(0, N - 1));
            len  = int'($urandom_range(0, 20));
            for (int i = 0; i <= len; i++) wdata[i] = D'($urandom);
            do_write(addr, len, int'($urandom_range(0, 2)), 2, -1);
            do_read(addr, len, int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
